// File: rtl/bp_pkg.sv
// Shared types and constants for the branch-predictor update queue.
// The record type fixes the field order {idx, taken} used throughout the queue.
package bp_pkg;

   localparam int BP_IDX_W = 6;

   typedef struct packed {
      logic [BP_IDX_W-1:0] idx;
      logic                taken;
   } bp_rec_t;

   localparam int BP_REC_W = $bits(bp_rec_t);

   function automatic int bp_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/bp_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; occupancy is the pointer difference.
// Synchronous clear empties the queue without touching the storage array.
module bp_sync_fifo
   import bp_pkg::*;
#(
   parameter  int W     = BP_REC_W,
   parameter  int DEPTH = 8,
   localparam int AW    = bp_clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr_i,
   input  logic          push_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          pop_i,
   output logic [W-1:0]  rdata_o,
   output logic          empty_o,
   output logic          full_o,
   output logic [AW:0]   occupancy_o
);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic         do_push;
   logic         do_pop;

   assign do_push = push_i & ~clr_i;
   assign do_pop  = pop_i  & ~clr_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

   assign rdata_o     = mem_q[rd_ptr_q[AW-1:0]];
   assign occupancy_o = wr_ptr_q - rd_ptr_q;
   assign empty_o     = (wr_ptr_q == rd_ptr_q);
   assign full_o      = (occupancy_o == (AW+1)'(DEPTH));

endmodule

// File: rtl/bp_update_queue.sv
// Buffers resolved branches from execute and replays them one per cycle as
// predictor update pulses, while keeping saturating resolve/mispredict counts.
module bp_update_queue
   import bp_pkg::*;
#(
   parameter  int IDX_W = BP_IDX_W,
   parameter  int DEPTH = 8,
   parameter  int CNT_W = 16,
   localparam int OCC_W = bp_clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IDX_W-1:0] in_idx,
   input  logic             in_taken,
   input  logic             in_pred,
   input  logic             flush,
   input  logic             upd_stall,
   output logic             upd_branch,
   output logic             upd_taken,
   output logic [IDX_W-1:0] upd_idx,
   output logic [OCC_W-1:0] occupancy,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam int REC_W = IDX_W + 1;

   logic             fifo_empty;
   logic             fifo_full;
   logic [REC_W-1:0] head_rec;
   logic             push;
   logic             pop;

   logic             upd_branch_q, upd_branch_d;
   logic             upd_taken_q,  upd_taken_d;
   logic [IDX_W-1:0] upd_idx_q,    upd_idx_d;
   logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

   // Flush blocks both ends so a flushed cycle neither accepts nor issues.
   assign in_ready = ~fifo_full & ~flush;
   assign push     = in_valid & in_ready;
   assign pop      = ~fifo_empty & ~upd_stall & ~flush;

   bp_sync_fifo #(
      .W     (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .clr_i       (flush),
      .push_i      (push),
      .wdata_i     ({in_idx, in_taken}),
      .pop_i       (pop),
      .rdata_o     (head_rec),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full),
      .occupancy_o (occupancy)
   );

   always_comb begin
      upd_branch_d = pop;
      upd_taken_d  = upd_taken_q;
      upd_idx_d    = upd_idx_q;
      if (pop) begin
         upd_idx_d   = head_rec[REC_W-1:1];
         upd_taken_d = head_rec[0];
      end
   end

   always_comb begin
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (push && (branch_cnt_q != '1)) branch_cnt_d = branch_cnt_q + 1'b1;
      if (push && (in_taken != in_pred) && (mispred_cnt_q != '1))
         mispred_cnt_d = mispred_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         upd_branch_q  <= 1'b0;
         upd_taken_q   <= 1'b0;
         upd_idx_q     <= '0;
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         upd_branch_q  <= upd_branch_d;
         upd_taken_q   <= upd_taken_d;
         upd_idx_q     <= upd_idx_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign upd_branch  = upd_branch_q;
   assign upd_taken   = upd_taken_q;
   assign upd_idx     = upd_idx_q;
   assign branch_cnt  = branch_cnt_q;
   assign mispred_cnt = mispred_cnt_q;

endmodule
